// File: rtl/switch_event_queue.sv
// switch_event_queue: captures switch snapshots on each input-stage pulse into a
// small FIFO tagged with a sequence number, raises irq while events are pending,
// and exposes an event word (addr 0) and a status word (addr 1) on the CPU bus.
module switch_event_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        event_pulse,
  input  logic [7:0]  switches,
  inout  wire  [31:0] data,
  input  logic        addr,
  input  logic        read,
  input  logic        write,
  output logic        irq
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic [7:0]       seq;
  logic [7:0]       drop_cnt;
  logic             overflow;
  logic             read_q;
  logic             addr_q;
  logic             empty;
  logic             full;
  logic             pop;
  logic             accept;
  logic             drop;
  logic             clear;
  logic [31:0]      rdata;
  logic             unused_bus;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  // Pop on the falling edge of an event-word strobe, so one strobe = one pop.
  assign pop    = read_q & ~addr_q & ~read & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign accept = event_pulse & (~full | pop);
  assign drop   = event_pulse & full & ~pop;
  assign clear  = write & addr & data[0];
  // Only bit 0 of the bus carries write data.
  assign unused_bus = ^data[31:1];

  // Next occupancy from the push/pop combination.
  always_comb begin
    count_nxt = count;
    case ({accept, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (reset && accept) begin
      mem[wr_ptr] <= {seq, switches};
    end
  end

  // Pointers, occupancy, sequence, overflow tracking and strobe history.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      read_q   <= 1'b0;
      addr_q   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      read_q <= read;
      addr_q <= addr;
      count  <= count_nxt;
      irq    <= (count_nxt != '0);
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (event_pulse) seq <= seq + 8'd1;
      if (clear) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Read mux: status word or head-of-queue event word (zero when empty).
  always_comb begin
    rdata = '0;
    if (addr) begin
      rdata[PTR_W:0] = count;
      rdata[8]       = empty;
      rdata[9]       = full;
      rdata[10]      = overflow;
      rdata[23:16]   = drop_cnt;
    end else if (!empty) begin
      rdata = {1'b1, 15'b0, mem[rd_ptr]};
    end
  end

  assign data = read ? rdata : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_switch_event_queue.sv
// Bench for switch_event_queue: directed scenarios plus a randomized phase,
// all checked against a queue-based behavioural model.
module tb_switch_event_queue;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        event_pulse;
  logic [7:0]  switches;
  wire  [31:0] data;
  logic        addr;
  logic        read;
  logic        write;
  logic        irq;

  logic        tb_drive;
  logic [31:0] tb_data;

  assign data = tb_drive ? tb_data : 32'hzzzz_zzzz;

  switch_event_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .event_pulse (event_pulse),
    .switches    (switches),
    .data        (data),
    .addr        (addr),
    .read        (read),
    .write       (write),
    .irq         (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic [15:0] mq [$];
  logic [7:0]  m_seq;
  logic        m_ovf;
  logic [7:0]  m_drop;
  logic        m_rq;
  logic        m_aq;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic a);
    logic [31:0] w;
    w = '0;
    if (a) begin
      w[2:0]   = 3'(mq.size());
      w[8]     = (mq.size() == 0);
      w[9]     = (mq.size() == DEPTH);
      w[10]    = m_ovf;
      w[23:16] = m_drop;
    end else if (mq.size() != 0) begin
      w = {1'b1, 15'b0, mq[0]};
    end
    return w;
  endfunction

  task automatic model_step();
    logic do_pop;
    logic was_full;
    logic clr;
    if (!reset) begin
      mq.delete();
      m_seq  = '0;
      m_ovf  = 1'b0;
      m_drop = '0;
      m_rq   = 1'b0;
      m_aq   = 1'b0;
      return;
    end
    do_pop   = m_rq && !m_aq && !read && (mq.size() != 0);
    was_full = (mq.size() == DEPTH);
    clr      = write && addr && tb_drive && tb_data[0];
    if (do_pop) void'(mq.pop_front());
    if (event_pulse) begin
      if (!was_full || do_pop) mq.push_back({m_seq, switches});
      else begin
        m_ovf = 1'b1;
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end
      m_seq = m_seq + 8'd1;
    end
    if (clr) begin
      m_ovf  = 1'b0;
      m_drop = '0;
    end
    m_rq = read;
    m_aq = addr;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_val("irq", {31'b0, irq}, {31'b0, mq.size() != 0});
    if (read) check_val(addr ? "status_rd" : "event_rd", data, exp_word(addr));
    else if (!tb_drive) check_val("bus_z", data, 32'hzzzz_zzzz);
  endtask

  task automatic do_reset();
    reset = 1'b0; read = 1'b0; write = 1'b0; event_pulse = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic pulse(input logic [7:0] sw);
    event_pulse = 1'b1;
    switches    = sw;
    cycle();
    event_pulse = 1'b0;
  endtask

  // Look at a register without crossing a clock edge (never pops).
  task automatic peek(input string tag, input logic a, input logic [31:0] lit);
    read = 1'b1;
    addr = a;
    #1;
    check_val(tag, data, lit);
    check_val({tag, "_model"}, data, exp_word(a));
    read = 1'b0;
    #1;
  endtask

  task automatic strobe(input logic a, input int len, input logic end_pulse, input logic [7:0] sw);
    read = 1'b1;
    addr = a;
    #1;
    check_val("strobe_start", data, exp_word(a));
    repeat (len) cycle();
    read        = 1'b0;
    event_pulse = end_pulse;
    switches    = sw;
    cycle();
    event_pulse = 1'b0;
  endtask

  task automatic bus_write(input logic a, input logic [31:0] v);
    tb_drive = 1'b1;
    tb_data  = v;
    write    = 1'b1;
    addr     = a;
    cycle();
    write    = 1'b0;
    tb_drive = 1'b0;
  endtask

  int rlen;
  int r;

  initial begin
    reset = 1'b0; event_pulse = 1'b0; switches = '0; addr = 1'b0;
    read = 1'b0; write = 1'b0; tb_drive = 1'b0; tb_data = '0;

    // reset state
    do_reset();
    cycle();
    check_val("rst_irq", {31'b0, irq}, 32'd0);
    peek("rst_status", 1'b1, 32'h0000_0100);
    peek("rst_event", 1'b0, 32'h0000_0000);

    // single event, long strobe gives one pop
    pulse(8'hA5);
    check_val("single_irq", {31'b0, irq}, 32'd1);
    peek("single_event", 1'b0, 32'h8000_00A5);
    strobe(1'b0, 3, 1'b0, 8'h00);
    check_val("single_irq_fall", {31'b0, irq}, 32'd0);
    peek("single_status", 1'b1, 32'h0000_0100);

    // fill and ordering
    do_reset();
    for (int i = 1; i <= 4; i++) pulse(8'(i));
    peek("fill_status", 1'b1, 32'h0000_0204);
    for (int i = 0; i < 4; i++) begin
      peek("fill_order", 1'b0, 32'h8000_0000 | (i << 8) | (i + 1));
      strobe(1'b0, 1, 1'b0, 8'h00);
    end
    peek("fill_empty", 1'b1, 32'h0000_0100);

    // overflow, clear, and sequence continuity past drops
    do_reset();
    for (int i = 0; i < 6; i++) pulse(8'(i));
    peek("ovf_status", 1'b1, 32'h0002_0604);
    bus_write(1'b0, 32'h1);
    peek("ovf_addr0_write", 1'b1, 32'h0002_0604);
    bus_write(1'b1, 32'h1);
    peek("ovf_cleared", 1'b1, 32'h0000_0204);
    repeat (4) strobe(1'b0, 1, 1'b0, 8'h00);
    pulse(8'h00);
    peek("ovf_seq6", 1'b0, 32'h8000_0600);
    strobe(1'b1, 2, 1'b0, 8'h00);
    peek("status_no_pop", 1'b0, 32'h8000_0600);

    // simultaneous push and pop while full
    do_reset();
    for (int i = 0; i < 4; i++) pulse(8'h11 + 8'(i));
    strobe(1'b0, 2, 1'b1, 8'h55);
    peek("simul_status", 1'b1, 32'h0000_0204);
    peek("simul_d0", 1'b0, 32'h8000_0112); strobe(1'b0, 1, 1'b0, 8'h00);
    peek("simul_d1", 1'b0, 32'h8000_0213); strobe(1'b0, 1, 1'b0, 8'h00);
    peek("simul_d2", 1'b0, 32'h8000_0314); strobe(1'b0, 1, 1'b0, 8'h00);
    peek("simul_d3", 1'b0, 32'h8000_0455); strobe(1'b0, 1, 1'b0, 8'h00);

    // reset in the middle of a strobe
    do_reset();
    pulse(8'h01);
    pulse(8'h02);
    read = 1'b1; addr = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    read = 1'b0;
    cycle();
    pulse(8'h07);
    peek("midrst_event", 1'b0, 32'h8000_0007);

    // drop counter saturation
    do_reset();
    repeat (300) pulse(8'h3C);
    peek("sat_status", 1'b1, 32'h00FF_0604);
    bus_write(1'b1, 32'h1);
    repeat (4) strobe(1'b0, 1, 1'b0, 8'h00);

    // sequence wrap with interleaved reads (seq passes FF -> 00)
    for (int i = 0; i < 260; i++) begin
      pulse(8'($urandom));
      strobe(1'b0, $urandom_range(1, 2), 1'b0, 8'h00);
    end

    // randomized traffic
    rlen = 0;
    for (int c = 0; c < 2000; c++) begin
      event_pulse = ($urandom_range(0, 3) == 0);
      switches    = 8'($urandom);
      if (rlen > 0) begin
        rlen--;
        if (rlen == 0) read = 1'b0;
      end else begin
        r = $urandom_range(0, 9);
        if (r < 4) begin
          read = 1'b1;
          addr = ($urandom_range(0, 3) == 0);
          rlen = $urandom_range(1, 4);
        end else if (r == 4) begin
          write    = 1'b1;
          addr     = 1'($urandom);
          tb_drive = 1'b1;
          tb_data  = $urandom;
        end
      end
      #1;
      if (read) check_val("rand_comb", data, exp_word(addr));
      cycle();
      write    = 1'b0;
      tb_drive = 1'b0;
    end
    read = 1'b0;
    event_pulse = 1'b0;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_event_queue.md
Name: switch_event_queue

Overview:
- Sits directly downstream of the switch input stage. Consumes its one-cycle `interupt` pulse and the raw `switches` byte.
- On each pulse it snapshots the switches into a small FIFO and tags each entry with a sequence number.
- Raises a level interrupt to the CPU while events are pending.
- The CPU drains events through the shared 32-bit tri-state data bus: address 0 is the event word, address 1 is status.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH); width of the read/write pointers.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clock.
- event_pulse  input  1  one-cycle-wide button event from the switch input stage.
- switches  input  8  raw switch value, sampled in the pulse cycle.
- data  inout  32  CPU data bus; driven only while read=1, else Z.
- addr  input  1  register select: 0 = event word, 1 = status.
- read  input  1  bus read strobe (level, may last several cycles).
- write  input  1  bus write strobe (level).
- irq  output  1  high while the FIFO is non-empty.

Behaviour:
- Reset (reset=0 at an edge) clears:
  - wr_ptr, rd_ptr, count, seq, overflow, drop_cnt, read_q, addr_q all to 0.
  - irq = 0.
  - data is Z whenever read=0, including during reset.
- Push: on an edge with event_pulse=1:
  - If count<DEPTH: write {seq, switches} at wr_ptr, then wr_ptr+1 (wraps mod DEPTH), count+1.
  - seq+1 on every pulse, accepted or dropped; 8-bit wrap 255->0.
- Push when full (count==DEPTH, no pop this cycle): entry is dropped, FIFO is unchanged, overflow<=1, drop_cnt+1 saturating at 255.
- Event word, read with addr=0:
  - data = {valid, 15'b0, seq_of_head[7:0], switches_of_head[7:0]}.
  - valid = (count!=0).
  - When empty, data = 32'h0000_0000.
  - Drives combinationally from the head while read=1, so data is stable for the whole strobe.
- Pop:
  - read_q and addr_q register read and addr every cycle.
  - Pop occurs on the edge where read_q=1, addr_q=0, read=0 (falling edge of the strobe): rd_ptr+1 wraps, count-1.
  - No pop if count==0.
  - Exactly one pop per strobe regardless of its length.
- Simultaneous push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - Applies when full too: the push is accepted, not dropped, and no overflow is raised.
  - Applies when empty (pop suppressed): push only.
- Status word, read with addr=1:
  - data[PTR_W:0] = count.
  - data[8] = empty.
  - data[9] = full.
  - data[10] = overflow.
  - data[23:16] = drop_cnt.
  - All other bits 0.
  - Reading status never pops.
- Write:
  - Status clear: on an edge with write=1, addr=1, data[0]=1, overflow<=0 and drop_cnt<=0.
  - If a drop occurs in the same cycle as a clear, the clear wins: overflow=0, drop_cnt=0.
  - Writes with addr=0 are ignored.
  - The block never drives data when write=1 without read.
- irq = registered (count!=0) after the update. It rises the cycle after the push edge and falls the cycle after the pop that empties the FIFO.
- Reset mid-strobe (read held high): queue is cleared and read_q=0, so no pop follows when read falls. data shows the empty word while read stays high.
- Latency:
  - Pulse at edge N: entry is readable and irq=1 after edge N.
  - Strobe end at edge M: next head is visible from edge M.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> irq=0; status read = 0x0000_0100; event read = 0x0000_0000; data=Z with read=0.
- Single event: switches=8'hA5, one pulse -> irq=1 next cycle; event read = 0x8000_00A5; 3-cycle read strobe then release -> exactly one pop; irq=0; status = 0x0000_0100.
- Fill and order: 4 pulses with switches 01,02,03,04 -> status count=4, full=1 (0x0000_0204); drain 4 reads -> 0x8000_0001, 0x8000_0102, 0x8000_0203, 0x8000_0304.
- Overflow: 6 pulses without reads -> status = 0x0002_0604 (drop_cnt=2, overflow, full, count 4); write addr=1 data=1 -> status = 0x0000_0204; next pulse after draining carries seq=6.
- Simultaneous: FIFO full; pulse coincides with the pop edge -> count stays 4, overflow stays 0, new entry appears last when drained.
- Sequence wrap: 256 pulses interleaved with reads -> seq field goes FF then 00; drop_cnt saturates at 255 under 300 unread pulses.
